// File: rtl/projection_pkg.sv
// Shared constants and FSM state type for the perspective projection stage.
package projection_pkg;
  localparam int Q15_SHIFT = 15;
  localparam int CX_DEF    = 160;
  localparam int CY_DEF    = 120;
  localparam int X_MAX_DEF = 319;
  localparam int Y_MAX_DEF = 239;

  typedef enum logic [2:0] {IDLE, MUL, ROT, DIV, DONE} proj_state_t;
endpackage

// File: rtl/proj_divider.sv
// Iterative restoring divider: two unsigned numerators share one denominator.
// o_done pulses in the final busy cycle; o_q carries the finished quotients then.
module proj_divider #(
  parameter int NUM_W = 19,
  parameter int DEN_W = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  i_start,
  input  logic [1:0][NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0]      i_den,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0][NUM_W-1:0] o_q
);
  localparam int CNT_W = $clog2(NUM_W);

  logic [1:0][NUM_W-1:0] r_num, w_num_nxt;
  logic [1:0][DEN_W-1:0] r_rem, w_rem_nxt;
  logic [DEN_W-1:0]      r_den;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;

  // Numerator register doubles as quotient: bits shift out the top, results in at the bottom.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DEN_W:0]   w_sh;
    logic [DEN_W+1:0] w_diff;
    assign w_sh           = {r_rem[gi], r_num[gi][NUM_W-1]};
    assign w_diff         = {1'b0, w_sh} - {2'b00, r_den};
    assign w_rem_nxt[gi]  = w_diff[DEN_W+1] ? w_sh[DEN_W-1:0] : w_diff[DEN_W-1:0];
    assign w_num_nxt[gi]  = {r_num[gi][NUM_W-2:0], ~w_diff[DEN_W+1]};
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CNT_W'(NUM_W-1));
  assign o_q    = w_num_nxt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_num  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_num  <= i_num;
      r_rem  <= '0;
      r_den  <= i_den;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_num <= w_num_nxt;
      r_rem <= w_rem_nxt;
      if (o_done) r_busy <= 1'b0;
      else        r_cnt  <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/perspective_projector.sv
// Rotate a voxel about Y by a Q1.15 cos/sin pair, perspective-divide by depth,
// then re-centre and clamp to the screen. One point in flight at a time.
module perspective_projector import projection_pkg::*; #(
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int Z_W         = 9,
  parameter int CX          = CX_DEF,
  parameter int CY          = CY_DEF,
  parameter int CZ          = 160,
  parameter int ZOFF        = 320,
  parameter int FOCAL_SHIFT = 8,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [15:0] cos,
  input  logic signed [15:0] sin,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [Z_W-1:0]     z_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic               clipped_out,
  output logic               valid_out,
  input  logic               ready_in
);
  localparam int MAG_W = ((X_W > Z_W) ? X_W : Z_W) + 2;
  localparam int NUM_W = MAG_W + FOCAL_SHIFT;
  localparam int DEP_W = MAG_W + 1;
  localparam int PX_W  = NUM_W + 2;

  proj_state_t r_state, w_state_nxt;

  logic signed [15:0]      r_cos, r_sin;
  logic signed [MAG_W-1:0] r_cx, r_cy, r_cz, w_cx, w_cy, w_cz;
  logic signed [31:0]      r_pxc, r_pzs, r_pxs, r_pzc;
  logic signed [32:0]      w_xsum, w_zsum;
  logic signed [DEP_W-1:0] w_xr, w_zr, w_depth;
  logic [DEP_W-1:0]        w_xabs;
  logic [MAG_W-1:0]        w_cyabs;
  logic                    w_cull;
  logic                    r_sx, r_sy;
  logic [1:0][NUM_W-1:0]   w_num, w_q;
  logic                    w_div_start, w_div_busy, w_div_done;
  logic signed [PX_W-1:0]  w_px, w_py;
  logic [X_W-1:0]          w_xo, r_x;
  logic [Y_W-1:0]          w_yo, r_y;
  logic                    w_xc, w_yc, r_clip, r_valid;

  assign w_cx = $signed(MAG_W'(x_in)) - $signed(MAG_W'(CX));
  assign w_cy = $signed(MAG_W'(y_in)) - $signed(MAG_W'(CY));
  assign w_cz = $signed(MAG_W'(z_in)) - $signed(MAG_W'(CZ));

  // Arithmetic shift floors, so small negative products land one below zero.
  assign w_xsum  = 33'(r_pxc) - 33'(r_pzs);
  assign w_zsum  = 33'(r_pxs) + 33'(r_pzc);
  assign w_xr    = DEP_W'(w_xsum >>> Q15_SHIFT);
  assign w_zr    = DEP_W'(w_zsum >>> Q15_SHIFT);
  assign w_depth = w_zr + $signed(DEP_W'(ZOFF));
  assign w_cull  = w_depth[DEP_W-1] || (w_depth == '0);
  assign w_xabs  = w_xr[DEP_W-1] ? DEP_W'(-w_xr) : DEP_W'(w_xr);
  assign w_cyabs = r_cy[MAG_W-1] ? MAG_W'(-r_cy) : MAG_W'(r_cy);

  assign w_num[0]    = NUM_W'(w_xabs) << FOCAL_SHIFT;
  assign w_num[1]    = NUM_W'(w_cyabs) << FOCAL_SHIFT;
  assign w_div_start = (r_state == ROT) && !w_cull;

  proj_divider #(.NUM_W(NUM_W), .DEN_W(DEP_W)) u_div (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   ($unsigned(w_depth)),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_q     (w_q)
  );

  assign w_px = (r_sx ? -$signed(PX_W'(w_q[0])) : $signed(PX_W'(w_q[0]))) + $signed(PX_W'(CX));
  assign w_py = (r_sy ? -$signed(PX_W'(w_q[1])) : $signed(PX_W'(w_q[1]))) + $signed(PX_W'(CY));

  always_comb begin
    w_xo = X_W'(w_px);
    w_xc = 1'b0;
    w_yo = Y_W'(w_py);
    w_yc = 1'b0;
    if (w_px[PX_W-1]) begin
      w_xo = '0;
      w_xc = 1'b1;
    end else if (w_px > $signed(PX_W'(X_MAX))) begin
      w_xo = X_W'(X_MAX);
      w_xc = 1'b1;
    end
    if (w_py[PX_W-1]) begin
      w_yo = '0;
      w_yc = 1'b1;
    end else if (w_py > $signed(PX_W'(Y_MAX))) begin
      w_yo = Y_W'(Y_MAX);
      w_yc = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_in) w_state_nxt = MUL;
      MUL:     w_state_nxt = ROT;
      ROT:     w_state_nxt = w_cull ? DONE : DIV;
      DIV:     if (w_div_done) w_state_nxt = DONE;
      DONE:    if (ready_in) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cos   <= '0;
      r_sin   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_cz    <= '0;
      r_pxc   <= '0;
      r_pzs   <= '0;
      r_pxs   <= '0;
      r_pzc   <= '0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_clip  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: if (valid_in) begin
          r_cos <= cos;
          r_sin <= sin;
          r_cx  <= w_cx;
          r_cy  <= w_cy;
          r_cz  <= w_cz;
        end
        MUL: begin
          r_pxc <= 32'(r_cx) * 32'(r_cos);
          r_pzs <= 32'(r_cz) * 32'(r_sin);
          r_pxs <= 32'(r_cx) * 32'(r_sin);
          r_pzc <= 32'(r_cz) * 32'(r_cos);
        end
        ROT: begin
          r_sx <= w_xr[DEP_W-1];
          r_sy <= r_cy[MAG_W-1];
          if (w_cull) begin
            r_x    <= X_W'(CX);
            r_y    <= Y_W'(CY);
            r_clip <= 1'b1;
          end
        end
        DIV: if (w_div_done) begin
          r_x    <= w_xo;
          r_y    <= w_yo;
          r_clip <= w_xc | w_yc;
        end
        default: ;
      endcase
    end
  end

  assign ready_out   = (r_state == IDLE) && !rst_in && !w_div_busy;
  assign x_out       = r_x;
  assign y_out       = r_y;
  assign clipped_out = r_clip;
  assign valid_out   = r_valid;
endmodule
